// File: rtl/sram_arbiter_pkg.sv
// Shared types and constants for the ibus/dbus to single-port SRAM arbiter.
// Imported by the top level and the watchdog counter.
package sram_arbiter_pkg;

  localparam int DEFAULT_TIMEOUT = 256;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    I_REQ  = 3'd1,
    D_REQ  = 3'd2,
    I_RESP = 3'd3,
    D_RESP = 3'd4,
    DRAIN  = 3'd5
  } arb_state_t;

  typedef enum logic {
    IBUS = 1'b0,
    DBUS = 1'b1
  } grant_t;

endpackage

// File: rtl/sram_arbiter_watchdog_counter.sv
// Saturating up-counter with synchronous clear and a terminal-count flag.
// Used to time out the response phase and the post-timeout drain phase.
module watchdog_counter
  import sram_arbiter_pkg::*;
#(
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic tc
);

  localparam int W = $clog2(TIMEOUT);
  localparam logic [W-1:0] LAST = W'(TIMEOUT - 1);

  logic [W-1:0] count;

  // Holding at LAST guarantees the count never wraps even if clear is late.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (enable && !tc) begin
      count <= count + 1'b1;
    end
  end

  assign tc = (count == LAST);

endmodule

// File: rtl/sram_arbiter.sv
// Merges the core's ibus and dbus onto one memory port, one transaction in flight,
// round-robin under contention, with a watchdog that turns lost responses into errors.
module sram_arbiter
  import sram_arbiter_pkg::*;
#(
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_addr_ok,
  output logic        i_data_ok,
  output logic [31:0] i_rdata,
  output logic        i_err,
  input  logic        d_req,
  input  logic        d_wr,
  input  logic [1:0]  d_size,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_addr_ok,
  output logic        d_data_ok,
  output logic [31:0] d_rdata,
  output logic        d_err,
  output logic        m_req,
  output logic        m_wr,
  output logic [1:0]  m_size,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  input  logic        m_addr_ok,
  input  logic        m_data_ok,
  input  logic [31:0] m_rdata,
  input  logic        m_err
);

  arb_state_t state, state_next;
  grant_t     last_grant, grant_next;
  logic       grant_load;
  logic       wd_clear, wd_enable, wd_tc;

  watchdog_counter #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .clk    (clk),
    .rst    (rst),
    .clear  (wd_clear),
    .enable (wd_enable),
    .tc     (wd_tc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= IBUS;
    end else begin
      state <= state_next;
      if (grant_load) begin
        last_grant <= grant_next;
      end
    end
  end

  always_comb begin
    state_next = state;
    grant_load = 1'b0;
    grant_next = last_grant;
    i_addr_ok  = 1'b0;
    i_data_ok  = 1'b0;
    i_rdata    = '0;
    i_err      = 1'b0;
    d_addr_ok  = 1'b0;
    d_data_ok  = 1'b0;
    d_rdata    = '0;
    d_err      = 1'b0;
    m_req      = 1'b0;
    m_wr       = 1'b0;
    m_size     = SZ_BYTE;
    m_addr     = '0;
    m_wdata    = '0;

    case (state)
      IDLE: begin
        if (i_req && d_req) begin
          state_next = (last_grant == IBUS) ? D_REQ : I_REQ;
        end else if (d_req) begin
          state_next = D_REQ;
        end else if (i_req) begin
          state_next = I_REQ;
        end
      end

      I_REQ: begin
        m_req     = 1'b1;
        m_size    = SZ_WORD;
        m_addr    = i_addr;
        i_addr_ok = m_addr_ok;
        if (m_addr_ok) begin
          state_next = I_RESP;
          grant_load = 1'b1;
          grant_next = IBUS;
        end
      end

      D_REQ: begin
        m_req     = 1'b1;
        m_wr      = d_wr;
        m_size    = d_size;
        m_addr    = d_addr;
        m_wdata   = d_wdata;
        d_addr_ok = m_addr_ok;
        if (m_addr_ok) begin
          state_next = D_RESP;
          grant_load = 1'b1;
          grant_next = DBUS;
        end
      end

      // A real response wins over a timeout landing in the same cycle.
      I_RESP: begin
        if (m_data_ok) begin
          i_data_ok  = 1'b1;
          i_rdata    = m_rdata;
          i_err      = m_err;
          state_next = IDLE;
        end else if (wd_tc) begin
          i_data_ok  = 1'b1;
          i_err      = 1'b1;
          state_next = DRAIN;
        end
      end

      D_RESP: begin
        if (m_data_ok) begin
          d_data_ok  = 1'b1;
          d_rdata    = m_rdata;
          d_err      = m_err;
          state_next = IDLE;
        end else if (wd_tc) begin
          d_data_ok  = 1'b1;
          d_err      = 1'b1;
          state_next = DRAIN;
        end
      end

      // A late slave response is absorbed here so it cannot leak into the next grant.
      DRAIN: begin
        if (m_data_ok || wd_tc) begin
          state_next = IDLE;
        end
      end

      default: state_next = IDLE;
    endcase
  end

  assign wd_enable = (state == I_RESP) || (state == D_RESP) || (state == DRAIN);
  assign wd_clear  = !wd_enable || (state_next != state);

endmodule
